key_sequence_recorder: RTL and testbench
========================================

# key_sequence_recorder

Capture-and-replay block for the piano key path. In RECORD mode it samples a 7-bit key code bus on a fixed-rate tick and stores the codes, including zero "rest" codes, in an internal buffer. In PLAY mode it drives the stored sequence back out at the same rate. It consumes what the song player produces (or live keys), and its playback output drives the same 7-bit key input the song player feeds.

## Interface
- DEPTH, 42: buffer capacity in steps (one step = one tick); pointer/length width = $clog2(DEPTH+1)
- TICK_COUNT, 16666666: divider reload value; tick period = TICK_COUNT+1 clock cycles
- LOOP, 0: 1 = playback restarts at step 0 after the last step; 0 = playback ends
- clock  in  1  system clock; every register updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rec_start  in  1  one-cycle request: clear buffer, begin recording
- play_start  in  1  one-cycle request: begin playback
- stop  in  1  one-cycle request: abort the current mode and return to IDLE
- keys_in  in  7  key code to record; 0 = rest
- keys_out  out  7  playback key code; 0 when not playing
- recording  out  1  high in RECORD
- playing  out  1  high in PLAY
- full  out  1  high when length == DEPTH
- length  out  $clog2(DEPTH+1)  number of stored steps

## Operation
- States: IDLE, RECORD, PLAY. Reset: IDLE, length=0, all pointers 0, divider = TICK_COUNT, all outputs 0. Buffer contents are undefined after reset and are never read beyond length.
- Divider: a down-counter that asserts tick when it is 0 and then reloads TICK_COUNT. On every accepted entry into RECORD or PLAY it is loaded with TICK_COUNT, so the first tick comes TICK_COUNT cycles after the entry cycle.
- Request priority in the same cycle: stop > rec_start > play_start. In RECORD and PLAY, rec_start and play_start are ignored. In IDLE, stop is a no-op.
- IDLE + rec_start: go to RECORD; length=0, wr_ptr=0.
- IDLE + play_start: go to PLAY if length>0, with rd_ptr=0. If length=0 the request is ignored.
- RECORD, on tick: mem[wr_ptr] = keys_in (zero codes are stored); wr_ptr++ and length++. When length becomes DEPTH, go to IDLE in the same edge.
- RECORD + stop: go to IDLE. Steps already written are kept; length is unchanged by stop.
- PLAY: keys_out is registered.
  - The cycle after entry, keys_out = mem[0].
  - On each tick, rd_ptr++ and keys_out = mem[rd_ptr+1].
  - On a tick with rd_ptr = length-1:
    - LOOP=0: go to IDLE, keys_out=0.
    - LOOP=1: rd_ptr=0, keys_out = mem[0].
- PLAY + stop: go to IDLE, keys_out=0 on the next cycle, rd_ptr=0.
- reset mid-operation: identical to power-on reset; the recording is lost (length=0).
- recording and playing are decoded from the state register; full is decoded from length.

## Timing
- Recording latency: keys_in is sampled on the tick edge. The value present during the tick cycle is stored.
- Playback: step k occupies keys_out for TICK_COUNT+1 cycles. The exceptions are step 0, which lasts TICK_COUNT+1 cycles measured from the cycle after the entry edge, and stop, which ends the current step at once.
- Total playback for LOOP=0: length×(TICK_COUNT+1) cycles from entry to the IDLE edge.
- Recorded step spacing equals playback step spacing, so a recording of the song player replays bit-identically. This holds if the player's divider phase matches; otherwise the replay is phase-shifted by at most one tick.

## Structure
- Shared package (key_pkg): KEY_W=7, the REST=7'd0 constant, and the state enum {IDLE, RECORD, PLAY}. The package is shared with the song player and the piano decoder.
- Sub-module tick_divider (TICK_COUNT parameter; ports clock, reset, load, tick). It replaces the ad-hoc divider and is also used by the song player.
- Buffer is an inferred DEPTH×7 array with an asynchronous read feeding the registered keys_out. It maps to LUT-RAM or flops.

## Test plan
Use TICK_COUNT=3 (period 4) and DEPTH=4 in simulation.
- Basic record and play:
  - Stimulus: reset; rec_start; drive keys_in 0x4D, 0x44, 0x43, 0x00 on successive ticks.
  - Required: length=4, full=1, and IDLE on the 4th tick edge.
  - Then play_start: keys_out = 0x4D, 0x44, 0x43, 0x00 for 4 cycles each, then 0 and playing=0 after 16 cycles.
- Empty playback: after reset, pulse play_start -> state stays IDLE and keys_out=0.
- Stop in each mode:
  - Stop during RECORD after 2 ticks -> length=2, IDLE.
  - Play that recording -> 2 steps. Stop during step 1 -> keys_out=0 on the next cycle.
- Simultaneous requests:
  - rec_start + play_start in IDLE -> RECORD.
  - stop + rec_start in PLAY -> IDLE.
  - play_start during RECORD -> ignored; length keeps counting.
- Loop and reset:
  - LOOP=1 with a 2-step recording 0x5B, 0x44 -> the sequence repeats 0x5B, 0x44, 0x5B, ... for 3 periods.
  - Assert reset mid-step -> all outputs 0 and length=0 on the next cycle.
- Re-record: after a full recording, rec_start -> length restarts at 0, and the old contents are not played beyond the new length.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the piano key path: key code width, rest code and
// the recorder mode encoding.
package key_pkg;

   localparam int unsigned KEY_W = 7;
   localparam logic [KEY_W-1:0] REST = 7'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } state_t;

endpackage

// File: rtl/key_sequence_recorder_if.sv
// Control and key-code bus of the key sequence recorder; the master issues
// requests and live keys, the slave returns playback keys and status.
interface key_sequence_recorder_if #(
   parameter int unsigned DEPTH = 42
);
   import key_pkg::*;

   localparam int unsigned LEN_W = $clog2(DEPTH + 1);

   logic             rec_start;
   logic             play_start;
   logic             stop;
   logic [KEY_W-1:0] keys_in;
   logic [KEY_W-1:0] keys_out;
   logic             recording;
   logic             playing;
   logic             full;
   logic [LEN_W-1:0] length;

   modport master (
      output rec_start, play_start, stop, keys_in,
      input  keys_out, recording, playing, full, length
   );

   modport slave (
      input  rec_start, play_start, stop, keys_in,
      output keys_out, recording, playing, full, length
   );

endinterface

// File: rtl/tick_divider.sv
// Fixed-rate step tick: down-counter that flags zero and reloads, with a
// load input to restart the phase.
module tick_divider #(
   parameter int unsigned TICK_COUNT = 16666666
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset || load) begin
         r_cnt <= CNT_W'(TICK_COUNT);
      end else if (r_cnt == '0) begin
         r_cnt <= CNT_W'(TICK_COUNT);
      end else begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign tick = (r_cnt == '0);

endmodule

// File: rtl/key_sequence_recorder.sv
// Capture-and-replay of the 7-bit key code stream, one buffer step per tick.
module key_sequence_recorder
   import key_pkg::*;
#(
   parameter int unsigned DEPTH      = 42,
   parameter int unsigned TICK_COUNT = 16666666,
   parameter bit          LOOP       = 1'b0
) (
   input logic                     clock,
   input logic                     reset,
   key_sequence_recorder_if.slave  bus
);

   localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           r_state;
   logic [LEN_W-1:0] r_length;
   logic [LEN_W-1:0] r_wr_ptr;
   logic [LEN_W-1:0] r_rd_ptr;
   logic [KEY_W-1:0] r_keys_out;
   logic [KEY_W-1:0] r_mem [DEPTH];

   logic             w_tick;
   logic             w_load;
   logic             w_wr_en;
   logic [LEN_W-1:0] w_rd_next;
   logic [KEY_W-1:0] w_mem_next;
   logic [KEY_W-1:0] w_mem_first;

   // Divider phase restarts on every accepted entry into RECORD or PLAY.
   assign w_load = (r_state == IDLE) &&
                   (bus.rec_start || (bus.play_start && (r_length != '0)));
   assign w_wr_en     = (r_state == RECORD) && w_tick && !bus.stop;
   assign w_rd_next   = r_rd_ptr + LEN_W'(1);
   assign w_mem_next  = r_mem[w_rd_next[ADDR_W-1:0]];
   assign w_mem_first = r_mem[0];

   tick_divider #(
      .TICK_COUNT (TICK_COUNT)
   ) u_tick_divider (
      .clock (clock),
      .reset (reset),
      .load  (w_load),
      .tick  (w_tick)
   );

   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.keys_in;
      end
   end

   // Mode control; stop outranks rec_start, which outranks play_start.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_length   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_keys_out <= REST;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.rec_start) begin
                  r_state  <= RECORD;
                  r_length <= '0;
                  r_wr_ptr <= '0;
               end else if (bus.play_start && (r_length != '0)) begin
                  r_state    <= PLAY;
                  r_rd_ptr   <= '0;
                  r_keys_out <= w_mem_first;
               end
            end
            RECORD: begin
               if (bus.stop) begin
                  r_state <= IDLE;
               end else if (w_tick) begin
                  r_wr_ptr <= r_wr_ptr + LEN_W'(1);
                  r_length <= r_length + LEN_W'(1);
                  if (r_length == LEN_W'(DEPTH - 1)) begin
                     r_state <= IDLE;
                  end
               end
            end
            PLAY: begin
               if (bus.stop) begin
                  r_state    <= IDLE;
                  r_rd_ptr   <= '0;
                  r_keys_out <= REST;
               end else if (w_tick) begin
                  if (w_rd_next == r_length) begin
                     r_rd_ptr <= '0;
                     if (LOOP) begin
                        r_keys_out <= w_mem_first;
                     end else begin
                        r_state    <= IDLE;
                        r_keys_out <= REST;
                     end
                  end else begin
                     r_rd_ptr   <= w_rd_next;
                     r_keys_out <= w_mem_next;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.keys_out  = r_keys_out;
   assign bus.recording = (r_state == RECORD);
   assign bus.playing   = (r_state == PLAY);
   assign bus.full      = (r_length == LEN_W'(DEPTH));
   assign bus.length    = r_length;

endmodule

// File: tb/tb_key_sequence_recorder.sv
// Bench for key_sequence_recorder: a one-shot and a looping instance share
// stimulus and are checked against a step-arithmetic reference model.
module tb_key_sequence_recorder;
   import key_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TICK  = 3;
   localparam int unsigned P     = TICK + 1;
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   key_sequence_recorder_if #(.DEPTH(DEPTH)) if0 ();
   key_sequence_recorder_if #(.DEPTH(DEPTH)) if1 ();

   key_sequence_recorder #(.DEPTH(DEPTH), .TICK_COUNT(TICK), .LOOP(1'b0)) dut0 (
      .clock (clk), .reset (rst), .bus (if0)
   );
   key_sequence_recorder #(.DEPTH(DEPTH), .TICK_COUNT(TICK), .LOOP(1'b1)) dut1 (
      .clock (clk), .reset (rst), .bus (if1)
   );

   int checks = 0;
   int errors = 0;

   // Reference: mode 0 idle, 1 record, 2 play; el = cycles since entry.
   int         mmode [2];
   int         mlen  [2];
   int         mel   [2];
   logic [6:0] mko   [2];
   logic [6:0] mbuf  [2][DEPTH];

   typedef struct {
      int         n;
      bit         rec_s, play_s, stop_s, rst_s;
      logic [6:0] keys;
      logic [6:0] e_ko;
      bit         e_rec, e_play, e_full;
      int         e_len;
   } vec_t;

   vec_t tv [$];

   function automatic vec_t mk(int n, bit rs, bit ps, bit st, bit rr, logic [6:0] k,
                               logic [6:0] ko, bit er, bit ep, bit ef, int el);
      vec_t v;
      v.n = n; v.rec_s = rs; v.play_s = ps; v.stop_s = st; v.rst_s = rr; v.keys = k;
      v.e_ko = ko; v.e_rec = er; v.e_play = ep; v.e_full = ef; v.e_len = el;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input int d, input bit loop, input bit rs, input bit ps,
                             input bit st, input bit rr, input logic [6:0] k);
      int step;
      if (rr) begin
         mmode[d] = 0; mlen[d] = 0; mel[d] = 0; mko[d] = 7'd0;
         return;
      end
      case (mmode[d])
         0: begin
            if (rs) begin
               mmode[d] = 1; mlen[d] = 0; mel[d] = 0;
            end else if (ps && mlen[d] > 0) begin
               mmode[d] = 2; mel[d] = 0; mko[d] = mbuf[d][0];
            end
         end
         1: begin
            if (st) mmode[d] = 0;
            else begin
               mel[d]++;
               if (mel[d] % P == 0) begin
                  mbuf[d][mlen[d]] = k;
                  mlen[d]++;
                  if (mlen[d] == DEPTH) mmode[d] = 0;
               end
            end
         end
         default: begin
            if (st) begin
               mmode[d] = 0; mko[d] = 7'd0;
            end else begin
               mel[d]++;
               if (mel[d] % P == 0) begin
                  step = mel[d] / P;
                  if (step < mlen[d])  mko[d] = mbuf[d][step];
                  else if (loop)       mko[d] = mbuf[d][step % mlen[d]];
                  else begin
                     mmode[d] = 0; mko[d] = 7'd0;
                  end
               end
            end
         end
      endcase
   endtask

   task automatic get(input int d, output logic [6:0] ko, output logic rec,
                      output logic pl, output logic fu, output logic [LEN_W-1:0] ln);
      if (d == 0) begin
         ko = if0.keys_out; rec = if0.recording; pl = if0.playing; fu = if0.full; ln = if0.length;
      end else begin
         ko = if1.keys_out; rec = if1.recording; pl = if1.playing; fu = if1.full; ln = if1.length;
      end
   endtask

   task automatic check_model(input int d);
      logic [6:0] ko; logic rec, pl, fu; logic [LEN_W-1:0] ln;
      get(d, ko, rec, pl, fu, ln);
      chk($sformatf("model d%0d keys_out", d), 32'(ko), 32'(mko[d]));
      chk($sformatf("model d%0d recording", d), 32'(rec), 32'(mmode[d] == 1));
      chk($sformatf("model d%0d playing", d), 32'(pl), 32'(mmode[d] == 2));
      chk($sformatf("model d%0d full", d), 32'(fu), 32'(mlen[d] == DEPTH));
      chk($sformatf("model d%0d length", d), 32'(ln), 32'(mlen[d]));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 ns later.
   task automatic cyc(input bit rs, input bit ps, input bit st, input bit rr, input logic [6:0] k);
      @(negedge clk);
      if0.rec_start = rs; if0.play_start = ps; if0.stop = st; if0.keys_in = k;
      if1.rec_start = rs; if1.play_start = ps; if1.stop = st; if1.keys_in = k;
      rst = rr;
      @(posedge clk);
      model_edge(0, 1'b0, rs, ps, st, rr, k);
      model_edge(1, 1'b1, rs, ps, st, rr, k);
      #1;
      check_model(0);
      check_model(1);
   endtask

   logic [6:0] lp [2];
   logic [6:0] ko; logic rec, pl, fu; logic [LEN_W-1:0] ln;

   initial begin
      if0.rec_start = 0; if0.play_start = 0; if0.stop = 0; if0.keys_in = '0;
      if1.rec_start = 0; if1.play_start = 0; if1.stop = 0; if1.keys_in = '0;
      for (int d = 0; d < 2; d++) begin
         mmode[d] = 0; mlen[d] = 0; mel[d] = 0; mko[d] = '0;
      end

      //          n rs ps st rr keys   ko    rec pl full len
      tv.push_back(mk(2, 0,0,0,1, 7'h00, 7'h00, 0,0,0, 0));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h00, 0,0,0, 0));
      tv.push_back(mk(1, 1,0,0,0, 7'h4D, 7'h00, 1,0,0, 0));
      tv.push_back(mk(4, 0,0,0,0, 7'h4D, 7'h00, 1,0,0, 1));
      tv.push_back(mk(4, 0,0,0,0, 7'h44, 7'h00, 1,0,0, 2));
      tv.push_back(mk(4, 0,0,0,0, 7'h43, 7'h00, 1,0,0, 3));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h00, 0,0,1, 4));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h4D, 0,1,1, 4));
      tv.push_back(mk(3, 0,0,0,0, 7'h00, 7'h4D, 0,1,1, 4));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h44, 0,1,1, 4));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h43, 0,1,1, 4));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h00, 0,1,1, 4));
      tv.push_back(mk(1, 0,0,0,0, 7'h00, 7'h00, 0,0,1, 4));
      tv.push_back(mk(1, 1,0,0,0, 7'h11, 7'h00, 1,0,0, 0));
      tv.push_back(mk(4, 0,0,0,0, 7'h11, 7'h00, 1,0,0, 1));
      tv.push_back(mk(1, 0,0,1,0, 7'h00, 7'h00, 0,0,0, 1));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h11, 0,1,0, 1));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h00, 0,0,0, 1));
      tv.push_back(mk(1, 1,0,0,0, 7'h21, 7'h00, 1,0,0, 0));
      tv.push_back(mk(4, 0,0,0,0, 7'h21, 7'h00, 1,0,0, 1));
      tv.push_back(mk(4, 0,0,0,0, 7'h22, 7'h00, 1,0,0, 2));
      tv.push_back(mk(1, 0,0,1,0, 7'h00, 7'h00, 0,0,0, 2));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h21, 0,1,0, 2));
      tv.push_back(mk(4, 0,0,0,0, 7'h00, 7'h22, 0,1,0, 2));
      tv.push_back(mk(1, 0,0,1,0, 7'h00, 7'h00, 0,0,0, 2));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h21, 0,1,0, 2));
      tv.push_back(mk(1, 1,0,1,0, 7'h00, 7'h00, 0,0,0, 2));
      tv.push_back(mk(1, 1,1,0,0, 7'h33, 7'h00, 1,0,0, 0));
      tv.push_back(mk(1, 0,1,0,0, 7'h33, 7'h00, 1,0,0, 0));
      tv.push_back(mk(3, 0,0,0,0, 7'h33, 7'h00, 1,0,0, 1));
      tv.push_back(mk(1, 0,0,1,0, 7'h00, 7'h00, 0,0,0, 1));
      tv.push_back(mk(1, 0,1,0,0, 7'h00, 7'h33, 0,1,0, 1));
      tv.push_back(mk(1, 0,0,0,0, 7'h00, 7'h33, 0,1,0, 1));
      tv.push_back(mk(1, 0,0,0,1, 7'h00, 7'h00, 0,0,0, 0));

      // Directed vectors: pulses in the first cycle, keys held, check at the end.
      for (int i = 0; i < tv.size(); i++) begin
         for (int c = 0; c < tv[i].n; c++) begin
            if (c == 0) cyc(tv[i].rec_s, tv[i].play_s, tv[i].stop_s, tv[i].rst_s, tv[i].keys);
            else        cyc(1'b0, 1'b0, 1'b0, 1'b0, tv[i].keys);
         end
         get(0, ko, rec, pl, fu, ln);
         chk($sformatf("vec%0d keys_out", i), 32'(ko), 32'(tv[i].e_ko));
         chk($sformatf("vec%0d recording", i), 32'(rec), 32'(tv[i].e_rec));
         chk($sformatf("vec%0d playing", i), 32'(pl), 32'(tv[i].e_play));
         chk($sformatf("vec%0d full", i), 32'(fu), 32'(tv[i].e_full));
         chk($sformatf("vec%0d length", i), 32'(ln), 32'(tv[i].e_len));
      end

      // Looping playback of a two-step recording over three full periods.
      lp[0] = 7'h5B;
      lp[1] = 7'h44;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'h5B);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 7'h5B);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 7'h44);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
      get(1, ko, rec, pl, fu, ln);
      chk("loop length", 32'(ln), 32'd2);
      for (int c = 0; c < 12; c++) begin
         if (c == 0) cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
         else        cyc(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
         get(1, ko, rec, pl, fu, ln);
         chk($sformatf("loop c%0d keys_out", c), 32'(ko), 32'(lp[(c / P) % 2]));
         chk($sformatf("loop c%0d playing", c), 32'(pl), 32'd1);
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);

      // Random requests and keys against the reference model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(29) == 0), ($urandom_range(19) == 0),
             ($urandom_range(39) == 0), ($urandom_range(199) == 0),
             7'($urandom_range(127)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
